// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Forwarding, load-use/RAW stall, branch flush and memory-freeze
//            control for the decode/execute stage, plus saturating counters.
//            Optional feature macro: HAZARD_FWD_EN (operand forwarding).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       fd_rs1_i,
    input  logic [4:0]       fd_rs2_i,
    input  logic             de_valid_i,
    input  logic [4:0]       de_rs1_i,
    input  logic [4:0]       de_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_reg_write_i,
    input  logic             de_mem_read_i,
    input  logic [4:0]       em_rd_i,
    input  logic [4:0]       mw_rd_i,
    input  logic             em_reg_write_i,
    input  logic             mw_reg_write_i,
    input  logic             branch_taken_i,
    input  logic             ext_stall_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             pc_stall_o,
    output logic             fd_stall_o,
    output logic             de_stall_o,
    output logic             em_stall_o,
    output logic             fd_flush_o,
    output logic             de_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        FREEZE    = 2'b01,
        FREEZE_PF = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_hazard;
    logic              w_flush;
    logic              w_stall;

    function automatic logic rd_match(input logic we, input logic [4:0] rd,
                                      input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

`ifdef HAZARD_FWD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = de_reg_write_i;

    // Memory stage is the younger producer, so it wins over writeback.
    assign w_fwd_a = rd_match(em_reg_write_i, em_rd_i, de_rs1_i) ? 2'b10 :
                     rd_match(mw_reg_write_i, mw_rd_i, de_rs1_i) ? 2'b01 : 2'b00;
    assign w_fwd_b = rd_match(em_reg_write_i, em_rd_i, de_rs2_i) ? 2'b10 :
                     rd_match(mw_reg_write_i, mw_rd_i, de_rs2_i) ? 2'b01 : 2'b00;
    assign w_hazard = de_valid_i && de_mem_read_i && (de_rd_i != 5'd0) &&
                      ((de_rd_i == fd_rs1_i) || (de_rd_i == fd_rs2_i));
`else
    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{de_rs1_i, de_rs2_i, de_mem_read_i};

    assign w_fwd_a  = 2'b00;
    assign w_fwd_b  = 2'b00;
    // Without bypass, any in-flight producer of a decode source must drain.
    assign w_hazard = rd_match(de_valid_i && de_reg_write_i, de_rd_i, fd_rs1_i) ||
                      rd_match(de_valid_i && de_reg_write_i, de_rd_i, fd_rs2_i) ||
                      rd_match(em_reg_write_i, em_rd_i, fd_rs1_i) ||
                      rd_match(em_reg_write_i, em_rd_i, fd_rs2_i) ||
                      rd_match(mw_reg_write_i, mw_rd_i, fd_rs1_i) ||
                      rd_match(mw_reg_write_i, mw_rd_i, fd_rs2_i);
`endif

    // A deferred flush fires on the first unfrozen cycle and absorbs a new branch.
    assign w_flush = !ext_stall_i && (branch_taken_i || (r_state == FREEZE_PF));
    assign w_stall = !ext_stall_i && w_hazard && !w_flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN, FREEZE: begin
                if (ext_stall_i)
                    w_state_nxt = branch_taken_i ? FREEZE_PF : FREEZE;
                else
                    w_state_nxt = RUN;
            end
            FREEZE_PF: begin
                if (!ext_stall_i)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign fwd_a_o     = rst_i ? 2'b00 : w_fwd_a;
    assign fwd_b_o     = rst_i ? 2'b00 : w_fwd_b;
    assign pc_stall_o  = !rst_i && (ext_stall_i || w_stall);
    assign fd_stall_o  = !rst_i && (ext_stall_i || w_stall);
    assign de_stall_o  = !rst_i && ext_stall_i;
    assign em_stall_o  = !rst_i && ext_stall_i;
    assign fd_flush_o  = !rst_i && w_flush;
    assign de_flush_o  = !rst_i && (w_flush || w_stall);
    assign state_o     = rst_i ? 2'b00 : r_state;
    assign stall_cnt_o = rst_i ? '0 : r_stall_cnt;
    assign flush_cnt_o = rst_i ? '0 : r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: stimulus pushes expected
// responses, a negedge monitor pops and compares.
`default_nettype none

module tb_hazard_control_unit;

    localparam int CNT_W = 16;

    // Output vector: {fwd_a, fwd_b, pc, fd, de, em, fd_flush, de_flush, state}
    localparam logic [11:0] V_ZERO = 12'h000;
    localparam logic [11:0] V_HZ   = 12'h0C4;
    localparam logic [11:0] V_FRZ  = 12'h0F0;
    localparam logic [11:0] V_FL   = 12'h00C;
    localparam logic [11:0] M_ALL  = 12'hFFF;
    localparam logic [11:0] M_NONE = 12'h000;

    logic clk, rst;
    logic [4:0] fd_rs1, fd_rs2, de_rs1, de_rs2, de_rd, em_rd, mw_rd;
    logic de_valid, de_reg_write, de_mem_read, em_we, mw_we, br, ext;
    logic [1:0] fwd_a, fwd_b, state;
    logic pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_control_unit #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .fd_rs1_i(fd_rs1), .fd_rs2_i(fd_rs2),
        .de_valid_i(de_valid), .de_rs1_i(de_rs1), .de_rs2_i(de_rs2),
        .de_rd_i(de_rd), .de_reg_write_i(de_reg_write), .de_mem_read_i(de_mem_read),
        .em_rd_i(em_rd), .mw_rd_i(mw_rd),
        .em_reg_write_i(em_we), .mw_reg_write_i(mw_we),
        .branch_taken_i(br), .ext_stall_i(ext),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .pc_stall_o(pc_stall), .fd_stall_o(fd_stall),
        .de_stall_o(de_stall), .em_stall_o(em_stall),
        .fd_flush_o(fd_flush), .de_flush_o(de_flush),
        .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    typedef struct {
        string       name;
        logic [11:0] exp;
        logic [11:0] mask;
        bit          chk_cnt;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } item_t;

    item_t q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    always @(negedge clk) begin : monitor
        item_t it;
        logic [11:0] act;
        if (q.size() > 0) begin
            it  = q.pop_front();
            act = {fwd_a, fwd_b, pc_stall, fd_stall, de_stall, em_stall,
                   fd_flush, de_flush, state};
            if (it.mask != 12'h000) begin
                n_cmp++;
                if ((act & it.mask) !== (it.exp & it.mask)) begin
                    n_fail++;
                    $display("FAIL %s: outputs got %h want %h", it.name,
                             act & it.mask, it.exp & it.mask);
                end
            end
            if (it.chk_cnt) begin
                n_cmp++;
                if (stall_cnt !== it.sc || flush_cnt !== it.fc) begin
                    n_fail++;
                    $display("FAIL %s_cnt: stall/flush got %h/%h want %h/%h", it.name,
                             stall_cnt, flush_cnt, it.sc, it.fc);
                end
            end
        end
    end

    task automatic idle();
        fd_rs1 = 0; fd_rs2 = 0; de_rs1 = 0; de_rs2 = 0; de_rd = 0;
        em_rd = 0; mw_rd = 0; de_valid = 0; de_reg_write = 0; de_mem_read = 0;
        em_we = 0; mw_we = 0; br = 0; ext = 0;
    endtask

    task automatic load_use();
        de_valid = 1; de_mem_read = 1; de_reg_write = 1; de_rd = 7; fd_rs2 = 7;
    endtask

    // Queue the expected response for the current cycle, then advance one clock.
    // Counter expectations advance from the vector: a hazard stall is a pc stall
    // without em stall; a flush is an fd_flush.
    task automatic step(input string nm, input logic [11:0] ev,
                        input logic [11:0] mk, input bit chk);
        item_t it;
        it.name = nm; it.exp = ev; it.mask = mk; it.chk_cnt = chk;
        it.sc = exp_sc[CNT_W-1:0]; it.fc = exp_fc[CNT_W-1:0];
        q.push_back(it);
        @(posedge clk); #1;
        if (ev[7] && !ev[4] && exp_sc < (1 << CNT_W) - 1) exp_sc++;
        if (ev[3] && exp_fc < (1 << CNT_W) - 1) exp_fc++;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;

        // Reset forces all outputs low even with active hazard inputs.
        ext = 1; em_rd = 5; em_we = 1; de_rs1 = 5; fd_rs1 = 5;
        exp_sc = 0; exp_fc = 0;
        step("rst_outputs", V_ZERO, M_ALL, 1);
        rst = 0; idle();
        step("post_reset", V_ZERO, M_ALL, 1);

`ifdef HAZARD_FWD_EN
        em_rd = 5; mw_rd = 5; em_we = 1; mw_we = 1; de_rs1 = 5;
        step("fwd_a_mem", 12'h800, M_ALL, 0);
        de_rs2 = 5;
        step("fwd_both_mem", 12'hA00, M_ALL, 0);
        em_we = 0;
        step("fwd_wb", 12'h500, M_ALL, 0);
        em_rd = 0; mw_rd = 0; em_we = 1;
        step("fwd_rd0", V_ZERO, M_ALL, 1);
        idle();
`else
        em_rd = 3; em_we = 1; fd_rs1 = 3; de_rs1 = 3; de_rs2 = 3;
        step("raw_mem", V_HZ, M_ALL, 0);
        em_rd = 0; em_we = 0; mw_rd = 3; mw_we = 1;
        step("raw_wb", V_HZ, M_ALL, 0);
        mw_rd = 0; mw_we = 0;
        step("raw_release", V_ZERO, M_ALL, 1);
        idle();
`endif

        load_use();
        step("load_use", V_HZ, M_ALL, 1);
        idle();
        step("load_use_done", V_ZERO, M_ALL, 1);

        load_use(); br = 1;
        step("branch_over_lu", V_FL, M_ALL, 1);
        idle();
        step("branch_done", V_ZERO, M_ALL, 1);

        load_use(); ext = 1;
        step("frz_enter", V_FRZ | 12'h000, M_ALL, 0);
        br = 1;
        step("frz_branch", V_FRZ | 12'h001, M_ALL, 0);
        br = 0;
        step("frz_pending", V_FRZ | 12'h002, M_ALL, 1);
        ext = 0;
        step("frz_exit_flush", V_FL | 12'h002, M_ALL, 0);
        idle();
        step("frz_back_run", V_ZERO, M_ALL, 1);

        ext = 1; br = 1;
        step("merge_enter", V_FRZ, M_ALL, 0);
        br = 0;
        step("merge_pending", V_FRZ | 12'h002, M_ALL, 0);
        ext = 0; br = 1;
        step("merge_flush", V_FL | 12'h002, M_ALL, 0);
        idle();
        step("merge_once", V_ZERO, M_ALL, 1);

        load_use();
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            step("sat_run", V_HZ, M_NONE, 0);
        idle();
        step("sat_hold", V_ZERO, M_ALL, 1);
        load_use();
        step("sat_more", V_HZ, M_ALL, 0);
        idle();
        step("sat_no_wrap", V_ZERO, M_ALL, 1);

        ext = 1; br = 1;
        step("rstfrz_enter", V_FRZ, M_ALL, 0);
        rst = 1; br = 0;
        exp_sc = 0; exp_fc = 0;
        step("rstfrz_reset", V_ZERO, M_ALL, 1);
        rst = 0; ext = 0;
        step("rstfrz_no_flush", V_ZERO, M_ALL, 1);
        step("rstfrz_idle", V_ZERO, M_ALL, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: queue left %0d want 0", q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
# hazard_control_unit

Consumer-side control for the decode/execute pipeline register. It reads the decode/execute register outputs together with execute/memory and memory/writeback destination info. From these it produces:
- operand forwarding selects,
- load-use and RAW stalls,
- branch/jump flushes,
- freeze handling for an external memory stall.

It also keeps saturating stall and flush event counters. It sits beside the execute stage and drives the stall/flush controls of the fetch/decode and decode/execute registers.

## Interface
Parameters:
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- fd_rs1_i / fd_rs2_i  input  5  source registers of the instruction in decode.
- de_valid_i  input  1  decode/execute register holds a real instruction.
- de_rs1_i / de_rs2_i  input  5  source registers of the instruction in execute.
- de_rd_i  input  5  destination register of the instruction in execute.
- de_reg_write_i, de_mem_read_i  input  1  execute-stage control bits.
- em_rd_i, mw_rd_i  input  5  destinations in memory and writeback.
- em_reg_write_i, mw_reg_write_i  input  1  write enables for those stages.
- branch_taken_i  input  1  one-cycle pulse from the branch unit when the EX branch or jump redirects the PC.
- ext_stall_i  input  1  data memory not ready; freeze the whole pipeline.
- fwd_a_o / fwd_b_o  output  2  ALU operand select: 00 = register file, 01 = writeback, 10 = memory stage.
- pc_stall_o, fd_stall_o  output  1  hold the PC and the fetch/decode register.
- de_stall_o, em_stall_o  output  1  hold the decode/execute and execute/memory registers.
- fd_flush_o, de_flush_o  output  1  clear the fetch/decode register / insert a bubble into decode/execute.
- state_o  output  2  FSM state (00 RUN, 01 FREEZE, 10 FREEZE_PF).
- stall_cnt_o, flush_cnt_o  output  CNT_W  saturating event counters.

## Operation
- Match definition: rd matches rs when write enable = 1, rd ≠ 0, and rd = rs.
- Forwarding (fwd_a_o uses de_rs1_i, fwd_b_o uses de_rs2_i):
  - memory-stage match → 10;
  - else writeback match → 01;
  - else 00.
  - Memory stage has priority over writeback.
- Load-use hazard: de_valid_i and de_mem_read_i are both 1, and de_rd_i (nonzero) equals fd_rs1_i or fd_rs2_i.
  - Response: pc_stall_o = fd_stall_o = de_flush_o = 1 for that cycle.
- Flush: branch_taken_i in RUN → fd_flush_o = de_flush_o = 1 for one cycle, with no stall.
  - A flush overrides a load-use stall in the same cycle; the stall is not counted.
- FSM:
  - RUN → FREEZE when ext_stall_i = 1 and branch_taken_i = 0.
  - RUN → FREEZE_PF when ext_stall_i = 1 and branch_taken_i = 1.
  - FREEZE → FREEZE_PF when branch_taken_i = 1 while still frozen.
  - FREEZE → RUN when ext_stall_i = 0.
  - FREEZE_PF → RUN when ext_stall_i = 0; fd_flush_o and de_flush_o pulse in that same cycle.
  - In FREEZE/FREEZE_PF, or whenever ext_stall_i = 1: all four *_stall_o = 1, all flushes = 0, no hazard stalls counted.
- Counters:
  - stall_cnt_o increments per hazard-stall cycle.
  - flush_cnt_o increments per flush pulse, including a deferred flush.
  - Both saturate at all-ones; neither wraps.

## Timing
- Stall, flush and forward outputs are combinational from the registered state and the current inputs, with zero latency.
- FSM and counters update on the rising edge of clk_i.
- Behaviour while rst_i = 1:
  - all outputs are forced to 0, including fwd = 00;
  - on the next edge, state = RUN, counters = 0 and any pending flush is discarded;
  - a reset during FREEZE_PF drops the pending flush.
- A deferred flush is emitted exactly once, in the first cycle with ext_stall_i = 0.
- If a new branch_taken_i pulse arrives in that same cycle, it merges into the single flush and is counted once.
- Simultaneous memory-stage and writeback matches on the same rs select 10.

## Configuration
- HAZARD_FWD_EN defined (forwarding compiled in):
  - forwarding operates as above;
  - only load-use hazards stall.
- HAZARD_FWD_EN undefined (no forwarding):
  - fwd_a_o = fwd_b_o = 00 permanently;
  - a RAW stall (pc_stall_o, fd_stall_o, de_flush_o) is raised whenever fd_rs1_i or fd_rs2_i matches de_rd_i (with de_valid_i and de_reg_write_i), em_rd_i or mw_rd_i;
  - the register file does not bypass, so stalls last up to 3 cycles;
  - each stall cycle is counted.

## Test plan
- Forwarding, with HAZARD_FWD_EN: em_rd = mw_rd = 5, both writes = 1, de_rs1 = 5 → fwd_a = 10. Drop em_reg_write → 01. Set rd = 0 → 00.
- Load-use: de_mem_read = 1, de_rd = 7, fd_rs2 = 7 → exactly one cycle of pc_stall = fd_stall = de_flush = 1; stall_cnt goes 0 → 1.
- Branch with simultaneous load-use: branch_taken pulse plus load-use in the same cycle → fd_flush = de_flush = 1, pc_stall = 0, flush_cnt +1, stall_cnt unchanged.
- Freeze with pending flush: ext_stall high for 3 cycles, branch pulse in cycle 1 → state FREEZE → FREEZE_PF; stalls = 1 and flushes = 0 while frozen; flush pulses once in the cycle ext_stall drops; state returns to RUN.
- Saturation: 2^CNT_W + 3 load-use cycles → stall_cnt_o holds 0xFFFF (CNT_W = 16). A reset mid-freeze → counters 0, state RUN, no flush.
- Without HAZARD_FWD_EN: em_rd = 3, em_reg_write = 1, fd_rs1 = 3, then the producer advances to writeback → stall for 2 cycles, released when mw clears; fwd outputs stay 00.
